memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Memory-side responder of the cache_control interface: accepts iREN/dREN/dWEN from
//  the i- and d-caches of CPUS cores and drives their iwait/dwait/iload/dload.
//  Arbitrates one request at a time onto the single-ported RAM and waits on ramstate.
//  Sits between caches and RAM inside memory_control.
// PARAMETERS
//  CPUS    2   number of cores (i+d port pair each); 1..4
//  ADDR_W  32  word address width
//  DATA_W  32  data word width
// PORTS
//  CLK       in   1              clock, rising edge
//  nRST      in   1              reset, synchronous, active-low
//  iREN      in   CPUS           per-core instruction read request
//  dREN      in   CPUS           per-core data read request
//  dWEN      in   CPUS           per-core data write request
//  iaddr     in   CPUS*ADDR_W    per-core instruction address
//  daddr     in   CPUS*ADDR_W    per-core data address
//  dstore    in   CPUS*DATA_W    per-core write data
//  iwait     out  CPUS           1 = instruction request not complete
//  dwait     out  CPUS           1 = data request not complete
//  iload     out  CPUS*DATA_W    instruction read data, valid when iwait[n]=0
//  dload     out  CPUS*DATA_W    data read data, valid when dwait[n]=0
//  ramREN    out  1              RAM read enable
//  ramWEN    out  1              RAM write enable
//  ramaddr   out  ADDR_W         RAM address
//  ramstore  out  DATA_W         RAM write data
//  ramload   in   DATA_W         RAM read data
//  ramstate  in   2              0 FREE, 1 BUSY, 2 ACCESS (done this cycle), 3 ERROR
//  err_cnt   out  8              saturating count of ERROR responses
// BEHAVIOUR
//  - Reset (nRST=0 at CLK): state IDLE, rr=0, err_cnt=0. Outputs while in IDLE/reset:
//    iwait=dwait=all 1, iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
//  - States: IDLE, ACCESS.
//  - IDLE: if any request pending, select one, register grant {core, kind, addr, data},
//    go ACCESS. No request -> stay IDLE.
//  - Selection: cores scanned starting at rr, wrapping modulo CPUS; first core with any
//    request wins. Within a core: dWEN > dREN > iREN. dWEN&dREN both set = write.
//  - ACCESS: drive ramWEN (write) or ramREN (read), ramaddr/ramstore from grant regs;
//    exactly one enable high. Other ports keep wait=1.
//    * ramstate=ACCESS: combinationally drop granted wait bit this cycle; read data:
//      granted iload/dload = ramload (all other load lanes 0). Next: IDLE,
//      rr = granted core+1 mod CPUS.
//    * ramstate=FREE/BUSY: hold, wait stays 1.
//    * ramstate=ERROR: wait stays 1, err_cnt+1 (saturate 255), next IDLE, rr unchanged
//      (same request re-arbitrated and retried).
//    * granted request deasserted by cache mid-ACCESS: drop enables next cycle, go IDLE,
//      no wait pulse, rr unchanged.
//  - Latency: request seen cycle N -> RAM enable cycle N+1 -> earliest wait=0 cycle N+1
//    (RAM ACCESS same cycle). Back-to-back: one IDLE cycle between grants.
//  - Wait low for exactly one cycle per completed request; never two ports same cycle.
//  - Caches must hold request/address/data stable until their wait drops.
//  - Reset mid-ACCESS: abort, enables low next cycle, no completion signalled.
// TESTING
//  1 Reset: nRST=0 2 cycles -> iwait=dwait=11, ramREN=ramWEN=0, err_cnt=0.
//  2 Single read: iREN[0]=1 iaddr=0x40, RAM ACCESS after 2 BUSY, ramload=0xDEADBEEF ->
//    ramREN=1 addr 0x40 for 3 cycles, iwait[0]=0 one cycle with iload[0]=0xDEADBEEF.
//  3 Priority: core0 iREN+dWEN (daddr=0x80, dstore=0x1234) -> write served first
//    (ramWEN=1, ramstore=0x1234), then read; dwait[0] drops before iwait[0].
//  4 Round-robin: both cores dREN held, RAM ACCESS immediate -> grants alternate
//    core0, core1, core0; each dwait pulse spaced 2 cycles.
//  5 Error retry: ramstate=ERROR on first attempt, ACCESS on second -> err_cnt=1,
//    same address re-issued, single wait pulse.
//  6 Reset mid-ACCESS: assert nRST=0 while ramstate=BUSY -> no wait pulse, enables 0.

Source files
------------

// File: rtl/memory_arbiter.sv
// Memory-side arbiter of the cache_control interface.
// Serialises i/d cache requests from CPUS cores onto one single-ported RAM.
// The fairness pointer rr_q advances only when a request completes.
// Within a core, data write beats data read, which beats instruction read.
module memory_arbiter #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*ADDR_W-1:0]   iaddr,
  input  logic [CPUS*ADDR_W-1:0]   daddr,
  input  logic [CPUS*DATA_W-1:0]   dstore,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*DATA_W-1:0]   iload,
  output logic [CPUS*DATA_W-1:0]   dload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [ADDR_W-1:0]        ramaddr,
  output logic [DATA_W-1:0]        ramstore,
  input  logic [DATA_W-1:0]        ramload,
  input  logic [1:0]               ramstate,
  output logic [7:0]               err_cnt
);

  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [CW:0]   CPUS_W   = (CW+1)'(CPUS);
  localparam logic [CW-1:0] LAST_CORE = CW'(CPUS - 1);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
  typedef enum logic [1:0] {K_IREAD = 2'd0, K_DREAD = 2'd1, K_DWRITE = 2'd2} kind_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       rr_q, rr_d;
  logic [CW-1:0]       g_core_q, g_core_d;
  kind_t               g_kind_q, g_kind_d;
  logic [ADDR_W-1:0]   g_addr_q, g_addr_d;
  logic [DATA_W-1:0]   g_data_q, g_data_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic                sel_found_s;
  logic [CW-1:0]       sel_core_s;
  kind_t               sel_kind_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic [CW:0]         scan_raw_s;
  logic [CW:0]         scan_wrap_s;
  logic [CW-1:0]       scan_idx_s;
  logic                req_live_s;
  logic                done_s;

  // Round-robin scan from rr_q: first core with any request wins, then pick its kind.
  always_comb begin
    sel_found_s = 1'b0;
    sel_core_s  = '0;
    sel_kind_s  = K_IREAD;
    scan_raw_s  = '0;
    scan_wrap_s = '0;
    scan_idx_s  = '0;
    for (int k = 0; k < CPUS; k++) begin
      scan_raw_s  = {1'b0, rr_q} + k[CW:0];
      scan_wrap_s = (scan_raw_s >= CPUS_W) ? (scan_raw_s - CPUS_W) : scan_raw_s;
      scan_idx_s  = scan_wrap_s[CW-1:0];
      if (!sel_found_s && (dWEN[scan_idx_s] || dREN[scan_idx_s] || iREN[scan_idx_s])) begin
        sel_found_s = 1'b1;
        sel_core_s  = scan_idx_s;
        if (dWEN[scan_idx_s]) begin
          sel_kind_s = K_DWRITE;
        end else if (dREN[scan_idx_s]) begin
          sel_kind_s = K_DREAD;
        end else begin
          sel_kind_s = K_IREAD;
        end
      end else begin
        sel_found_s = sel_found_s;
      end
    end
    if (sel_kind_s == K_IREAD) begin
      sel_addr_s = iaddr[int'(sel_core_s)*ADDR_W +: ADDR_W];
    end else begin
      sel_addr_s = daddr[int'(sel_core_s)*ADDR_W +: ADDR_W];
    end
    if (sel_kind_s == K_DWRITE) begin
      sel_data_s = dstore[int'(sel_core_s)*DATA_W +: DATA_W];
    end else begin
      sel_data_s = '0;
    end
  end

  // Is the cache still asserting the request that currently holds the grant?
  always_comb begin
    case (g_kind_q)
      K_IREAD:  req_live_s = iREN[g_core_q];
      K_DREAD:  req_live_s = dREN[g_core_q];
      K_DWRITE: req_live_s = dWEN[g_core_q];
      default:  req_live_s = 1'b0;
    endcase
    done_s = nRST && (state_q == ACCESS) && req_live_s && (ramstate == RS_ACCESS);
  end

  // Next-state logic: grant in IDLE, then complete, retry on error or abort on withdrawal.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    g_core_d  = g_core_q;
    g_kind_d  = g_kind_q;
    g_addr_d  = g_addr_q;
    g_data_d  = g_data_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_found_s) begin
          state_d  = ACCESS;
          g_core_d = sel_core_s;
          g_kind_d = sel_kind_s;
          g_addr_d = sel_addr_s;
          g_data_d = sel_data_s;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!req_live_s) begin
          // Cache withdrew the request: release the RAM, keep fairness pointer.
          state_d = IDLE;
        end else if (ramstate == RS_ACCESS) begin
          state_d = IDLE;
          rr_d    = (g_core_q == LAST_CORE) ? '0 : (g_core_q + CW'(1));
        end else if (ramstate == RS_ERROR) begin
          // Same request will win again from the unchanged pointer and be retried.
          state_d   = IDLE;
          err_cnt_d = (err_cnt_q == 8'hFF) ? 8'hFF : (err_cnt_q + 8'd1);
        end else begin
          state_d = ACCESS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and grant registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      g_core_q  <= '0;
      g_kind_q  <= K_IREAD;
      g_addr_q  <= '0;
      g_data_q  <= '0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      g_core_q  <= g_core_d;
      g_kind_q  <= g_kind_d;
      g_addr_q  <= g_addr_d;
      g_data_q  <= g_data_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Output drive: RAM port from grant registers, wait/load lanes released on completion.
  always_comb begin
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (state_q == ACCESS) begin
      ramREN   = (g_kind_q != K_DWRITE);
      ramWEN   = (g_kind_q == K_DWRITE);
      ramaddr  = g_addr_q;
      ramstore = g_data_q;
      if (done_s) begin
        case (g_kind_q)
          K_IREAD: begin
            iwait[g_core_q] = 1'b0;
            iload[int'(g_core_q)*DATA_W +: DATA_W] = ramload;
          end
          K_DREAD: begin
            dwait[g_core_q] = 1'b0;
            dload[int'(g_core_q)*DATA_W +: DATA_W] = ramload;
          end
          K_DWRITE: begin
            dwait[g_core_q] = 1'b0;
          end
          default: begin
            iwait = '1;
          end
        endcase
      end else begin
        iwait = '1;
      end
    end else begin
      iwait = '1;
    end
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios, then randomized
// cache/RAM traffic checked against a behavioural model (memory array, pending
// request table, round-robin pointer, error tally).
module tb_memory_arbiter;

  localparam int CPUS = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACC = 2'd2, RS_ERR = 2'd3;

  logic                 CLK = 1'b0;
  logic                 nRST;
  logic [CPUS-1:0]      iREN, dREN, dWEN;
  logic [CPUS*AW-1:0]   iaddr, daddr;
  logic [CPUS*DW-1:0]   dstore;
  logic [CPUS-1:0]      iwait, dwait;
  logic [CPUS*DW-1:0]   iload, dload;
  logic                 ramREN, ramWEN;
  logic [AW-1:0]        ramaddr;
  logic [DW-1:0]        ramstore, ramload;
  logic [1:0]           ramstate;
  logic [7:0]           err_cnt;

  memory_arbiter #(.CPUS(CPUS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload),
    .ramstate(ramstate), .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_miscmp = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = RS_FREE;
  endtask

  // ---------------- random-phase model state ----------------
  bit            i_pend[CPUS], d_pend[CPUS], d_wr[CPUS], d_both[CPUS];
  bit            i_done[CPUS], d_done[CPUS];
  bit            snap_i[CPUS], snap_d[CPUS], snap_wr[CPUS];
  logic [AW-1:0] ia[CPUS], da[CPUS];
  logic [DW-1:0] ds[CPUS];
  int            age_i[CPUS], age_d[CPUS];
  logic [DW-1:0] mem_m[256];
  int            rr_m, n_err_m, lat, n_low, exp_c;
  bit            ram_act, will_err, prev_en, en;
  logic [1:0]    exp_pat;

  task automatic drive_caches();
    for (int c = 0; c < CPUS; c++) begin
      iREN[c] = i_pend[c];
      dREN[c] = d_pend[c] && (!d_wr[c] || d_both[c]);
      dWEN[c] = d_pend[c] && d_wr[c];
      iaddr[c*AW +: AW]  = ia[c];
      daddr[c*AW +: AW]  = da[c];
      dstore[c*DW +: DW] = ds[c];
    end
  endtask

  initial begin
    nRST = 1'b0;
    clear_inputs();

    // 1: reset state
    step(); step();
    check("rst_iwait", iwait, 2'b11);
    check("rst_dwait", dwait, 2'b11);
    check("rst_ramREN", ramREN, 1'b0);
    check("rst_ramWEN", ramWEN, 1'b0);
    check("rst_errcnt", err_cnt, 8'd0);
    nRST = 1'b1;

    // 2: single instruction read, two BUSY cycles then ACCESS
    iREN[0] = 1'b1; iaddr[0 +: AW] = 32'h40; ramstate = RS_FREE;
    settle();
    check("rd_idle_ren", ramREN, 1'b0);
    step(); ramstate = RS_BUSY; settle();
    check("rd_ren1", ramREN, 1'b1);
    check("rd_addr", ramaddr, 32'h40);
    check("rd_wait_busy1", iwait, 2'b11);
    step(); ramstate = RS_BUSY; settle();
    check("rd_ren2", ramREN, 1'b1);
    check("rd_wait_busy2", iwait, 2'b11);
    step(); ramstate = RS_ACC; ramload = 32'hDEADBEEF; settle();
    check("rd_ren3", ramREN, 1'b1);
    check("rd_iwait", iwait, 2'b10);
    check("rd_iload0", iload[0 +: DW], 32'hDEADBEEF);
    check("rd_iload1", iload[DW +: DW], 32'h0);
    step(); iREN = '0; ramstate = RS_FREE; settle();
    check("rd_after_wait", iwait, 2'b11);
    check("rd_after_ren", ramREN, 1'b0);

    // 3: write beats instruction read on the same core
    iREN[0] = 1'b1; iaddr[0 +: AW] = 32'h44;
    dWEN[0] = 1'b1; daddr[0 +: AW] = 32'h80; dstore[0 +: DW] = 32'h1234;
    settle();
    check("pri_idle_wen", ramWEN, 1'b0);
    step(); ramstate = RS_ACC; settle();
    check("pri_wen", ramWEN, 1'b1);
    check("pri_ren_off", ramREN, 1'b0);
    check("pri_store", ramstore, 32'h1234);
    check("pri_waddr", ramaddr, 32'h80);
    check("pri_dwait", dwait, 2'b10);
    check("pri_iwait_hold", iwait, 2'b11);
    step(); dWEN = '0; ramstate = RS_FREE; settle();
    check("pri_gap_en", {ramREN, ramWEN}, 2'b00);
    step(); ramstate = RS_ACC; ramload = 32'h5555; settle();
    check("pri_ren", ramREN, 1'b1);
    check("pri_raddr", ramaddr, 32'h44);
    check("pri_iwait", iwait, 2'b10);
    check("pri_iload", iload[0 +: DW], 32'h5555);
    step(); iREN = '0; ramstate = RS_FREE; settle();

    // 4: round robin between two held data reads
    nRST = 1'b0; step(); nRST = 1'b1;
    dREN = 2'b11; daddr[0 +: AW] = 32'h100; daddr[AW +: AW] = 32'h200; ramstate = RS_ACC;
    settle();
    check("rr_idle", dwait, 2'b11);
    for (int g = 0; g < 3; g++) begin
      step(); ramload = 32'hD0 + g; settle();
      exp_pat = ((g % 2) == 0) ? 2'b10 : 2'b01;
      check("rr_addr", ramaddr, ((g % 2) == 0) ? 32'h100 : 32'h200);
      check("rr_dwait", dwait, exp_pat);
      check("rr_dload", dload[(g % 2)*DW +: DW], 32'hD0 + g);
      step();
      if (g == 2) dREN = '0;
      settle();
      check("rr_gap", dwait, 2'b11);
    end

    // 5: error then retry of the same address
    ramstate = RS_FREE; dREN[1] = 1'b1; daddr[AW +: AW] = 32'h300; settle();
    step(); ramstate = RS_ERR; settle();
    check("err_ren", ramREN, 1'b1);
    check("err_addr", ramaddr, 32'h300);
    check("err_nowait", dwait, 2'b11);
    step(); ramstate = RS_FREE; settle();
    check("err_cnt1", err_cnt, 8'd1);
    check("err_gap_ren", ramREN, 1'b0);
    step(); ramstate = RS_ACC; ramload = 32'hCAFE; settle();
    check("err_retry_addr", ramaddr, 32'h300);
    check("err_retry_wait", dwait, 2'b01);
    check("err_retry_load", dload[DW +: DW], 32'hCAFE);
    step(); dREN = '0; ramstate = RS_FREE; settle();
    check("err_done_wait", dwait, 2'b11);
    check("err_cnt_hold", err_cnt, 8'd1);

    // 6: reset during ACCESS
    iREN[0] = 1'b1; iaddr[0 +: AW] = 32'h60; settle();
    step(); ramstate = RS_BUSY; nRST = 1'b0; settle();
    check("rstacc_wait", iwait, 2'b11);
    step(); ramstate = RS_FREE; settle();
    check("rstacc_en", {ramREN, ramWEN}, 2'b00);
    check("rstacc_wait2", iwait, 2'b11);
    check("rstacc_errcnt", err_cnt, 8'd0);
    iREN = '0; nRST = 1'b1;

    // 7: cache withdraws its granted request
    iREN[1] = 1'b1; iaddr[AW +: AW] = 32'h70; ramstate = RS_BUSY;
    step(); settle();
    check("abort_ren", ramREN, 1'b1);
    check("abort_addr", ramaddr, 32'h70);
    step(); iREN[1] = 1'b0; settle();
    check("abort_nowait", iwait, 2'b11);
    step(); settle();
    check("abort_en_off", ramREN, 1'b0);
    check("abort_wait_off", iwait, 2'b11);

    // Randomized traffic against the behavioural model
    for (int k = 0; k < 256; k++) mem_m[k] = 32'hA5000000 + k;
    for (int c = 0; c < CPUS; c++) begin
      i_pend[c] = 0; d_pend[c] = 0; d_wr[c] = 0; d_both[c] = 0;
      i_done[c] = 0; d_done[c] = 0; snap_i[c] = 0; snap_d[c] = 0; snap_wr[c] = 0;
      ia[c] = '0; da[c] = '0; ds[c] = '0; age_i[c] = 0; age_d[c] = 0;
    end
    clear_inputs();
    nRST = 1'b0; step(); step(); nRST = 1'b1;
    rr_m = 0; n_err_m = 0; ram_act = 0; will_err = 0; lat = 0; prev_en = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge CLK); #1;
      for (int c = 0; c < CPUS; c++) begin
        if (i_done[c]) begin i_pend[c] = 0; i_done[c] = 0; end
        if (d_done[c]) begin d_pend[c] = 0; d_done[c] = 0; end
        if (!i_pend[c] && $urandom_range(0, 2) == 0) begin
          i_pend[c] = 1;
          ia[c] = AW'($urandom_range(0, 63) * 4 + c * 2);
        end
        if (!d_pend[c] && $urandom_range(0, 2) == 0) begin
          d_pend[c] = 1;
          d_wr[c]   = ($urandom_range(0, 1) == 1);
          d_both[c] = d_wr[c] && ($urandom_range(0, 1) == 1);
          da[c] = AW'($urandom_range(0, 63) * 4 + c * 2 + 1);
          ds[c] = $urandom;
        end
      end
      drive_caches();

      @(negedge CLK);
      en = ramREN || ramWEN;
      // new grant: must be first requesting core from rr_m, highest-priority kind
      if (en && !prev_en) begin
        exp_c = -1;
        for (int k = 0; k < CPUS; k++) begin
          if (exp_c < 0 && (snap_i[(rr_m + k) % CPUS] || snap_d[(rr_m + k) % CPUS]))
            exp_c = (rr_m + k) % CPUS;
        end
        check("grant_has_req", (exp_c >= 0), 1'b1);
        if (exp_c >= 0) begin
          check("grant_core", ramaddr[1], exp_c[0]);
          check("grant_is_d", ramaddr[0], snap_d[exp_c]);
          check("grant_wen", ramWEN, snap_d[exp_c] && snap_wr[exp_c]);
        end
      end
      // RAM responder
      if (en) begin
        if (!ram_act) begin
          ram_act = 1; lat = $urandom_range(0, 3); will_err = ($urandom_range(0, 9) == 0);
        end
        if (lat > 0) begin
          ramstate = RS_BUSY; lat--;
        end else if (will_err) begin
          ramstate = RS_ERR; ram_act = 0;
        end else begin
          ramstate = RS_ACC; ramload = mem_m[ramaddr[7:0]]; ram_act = 0;
        end
      end else begin
        ramstate = RS_FREE; ram_act = 0; ramload = $urandom;
      end
      #1;
      check("r_errcnt", err_cnt, n_err_m);
      n_low = 0;
      for (int c = 0; c < CPUS; c++) begin
        if (!iwait[c]) begin
          n_low++;
          check("r_i_pend", i_pend[c], 1'b1);
          check("r_i_addr", ramaddr, ia[c]);
          check("r_i_ren", ramREN, 1'b1);
          check("r_iload", iload[c*DW +: DW], mem_m[ia[c][7:0]]);
          i_done[c] = 1; rr_m = (c + 1) % CPUS;
        end
        if (!dwait[c]) begin
          n_low++;
          check("r_d_pend", d_pend[c], 1'b1);
          check("r_d_addr", ramaddr, da[c]);
          if (d_wr[c]) begin
            check("r_d_wen", ramWEN, 1'b1);
            check("r_d_store", ramstore, ds[c]);
            mem_m[da[c][7:0]] = ds[c];
          end else begin
            check("r_d_ren", ramREN, 1'b1);
            check("r_dload", dload[c*DW +: DW], mem_m[da[c][7:0]]);
          end
          d_done[c] = 1; rr_m = (c + 1) % CPUS;
        end
      end
      check("r_wait_count", n_low, (en && ramstate == RS_ACC) ? 1 : 0);
      if (en && ramstate == RS_ERR && n_err_m < 255) n_err_m++;
      for (int c = 0; c < CPUS; c++) begin
        snap_i[c] = i_pend[c] && !i_done[c];
        snap_d[c] = d_pend[c] && !d_done[c];
        snap_wr[c] = d_wr[c];
        // a request completing this cycle is still asserted during it
        if (i_done[c]) snap_i[c] = 1;
        if (d_done[c]) snap_d[c] = 1;
        age_i[c] = i_pend[c] ? age_i[c] + 1 : 0;
        age_d[c] = d_pend[c] ? age_d[c] + 1 : 0;
        if (age_i[c] == 300) check("i_timeout", age_i[c], 0);
        if (age_d[c] == 300) check("d_timeout", age_d[c], 0);
      end
      prev_en = en;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
